// File: rtl/alu_pkg.sv
// Shared opcodes, scheduler state encoding and divide-by-zero result fill for the ALU scheduler.
// Used by alu_core and alu_rr_sched.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   // Divide-by-zero result is every result bit set to this value.
   localparam logic DZ_FILL = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: zero-extended add/sub/mul/div.
// A divide by zero returns an all-ones result and raises dz.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         s,
   output logic [2*WIDTH-1:0] y,
   output logic               dz
);

   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;

   assign a_ext = {{WIDTH{1'b0}}, a};
   assign b_ext = {{WIDTH{1'b0}}, b};

   always_comb begin
      y  = '0;
      dz = 1'b0;
      unique case (s)
         OP_ADD: y = a_ext + b_ext;
         OP_SUB: y = a_ext - b_ext;
         OP_MUL: y = a_ext * b_ext;
         OP_DIV: begin
            if (b == '0) begin
               y  = {(2*WIDTH){DZ_FILL}};
               dz = 1'b1;
            end else begin
               y = a_ext / b_ext;
            end
         end
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_RR_STATS_EN to add saturating per-requester grant counters.
module alu_rr_sched
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic [1:0]         req0_s,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   input  logic [1:0]         req1_s,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [2*WIDTH-1:0] rsp_y,
   output logic               rsp_dz
`ifdef ALU_RR_STATS_EN
   ,
   output logic [15:0]        stat_grant0,
   output logic [15:0]        stat_grant1
`endif
);

   state_t             state;
   logic               last_grant;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [1:0]         op_s;
   logic               op_id;

   logic               any_valid;
   logic               grant_id;
   logic               hs0;
   logic               hs1;
   logic [2*WIDTH-1:0] core_y;
   logic               core_dz;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      req0_ready = rst_n && (state == IDLE) && any_valid && !grant_id;
      req1_ready = rst_n && (state == IDLE) && any_valid && grant_id;
   end

   assign hs0 = req0_valid & req0_ready;
   assign hs1 = req1_valid & req1_ready;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a  (op_a),
      .b  (op_b),
      .s  (op_s),
      .y  (core_y),
      .dz (core_dz)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         op_s       <= OP_ADD;
         op_id      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_y      <= '0;
         rsp_dz     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (hs0 || hs1) begin
                  op_a       <= hs1 ? req1_a : req0_a;
                  op_b       <= hs1 ? req1_b : req0_b;
                  op_s       <= hs1 ? req1_s : req0_s;
                  op_id      <= hs1;
                  last_grant <= hs1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_y     <= core_y;
               rsp_dz    <= core_dz;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_RR_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_grant0 <= '0;
         stat_grant1 <= '0;
      end else begin
         if (hs0 && (stat_grant0 != 16'hFFFF)) stat_grant0 <= stat_grant0 + 16'd1;
         if (hs1 && (stat_grant1 != 16'hFFFF)) stat_grant1 <= stat_grant1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed table, hand-written corner sequences and
// randomized traffic checked against an arithmetic/round-robin reference model.
module tb_alu_rr_sched;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [7:0]  req0_a, req0_b;
   logic [1:0]  req0_s;
   logic        req1_valid, req1_ready;
   logic [7:0]  req1_a, req1_b;
   logic [1:0]  req1_s;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_dz;
   logic [15:0] rsp_y;
`ifdef ALU_RR_STATS_EN
   logic [15:0] stat_grant0, stat_grant1;
`endif

   int checks = 0;
   int errors = 0;
   int last_winner = 1;

   alu_rr_sched #(
      .WIDTH (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_s     (req0_s),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_s     (req1_s),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_y      (rsp_y),
      .rsp_dz     (rsp_dz)
`ifdef ALU_RR_STATS_EN
      ,
      .stat_grant0 (stat_grant0),
      .stat_grant1 (stat_grant1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         id;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] s;
      logic [15:0] y;
      bit         dz;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic on plain integers: {dz, y}.
   function automatic logic [16:0] ref_alu(input int a, input int b, input int s);
      int y;
      bit dz;
      dz = 1'b0;
      case (s)
         0: y = a + b;
         1: y = (a - b + 65536) % 65536;
         2: y = a * b;
         default: begin
            if (b == 0) begin
               y  = 65535;
               dz = 1'b1;
            end else begin
               y = a / b;
            end
         end
      endcase
      return {dz, y[15:0]};
   endfunction

   // Called at a negedge while the DUT is idle; returns at a negedge back in idle.
   task automatic run_txn(input bit v0, input bit v1,
                          input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] s0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] s1,
                          input int hold,
                          output logic [15:0] oy, output logic odz, output logic oid);
      int w;
      logic [16:0] r;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_s = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_s = s1;
      rsp_ready  = 1'($urandom_range(0, 1));
      #1;
      w = (v0 && v1) ? 1 - last_winner : (v1 ? 1 : 0);
      chk("req0_ready_idle", 32'(req0_ready), 32'(w == 0));
      chk("req1_ready_idle", 32'(req1_ready), 32'(w == 1));
      last_winner = w;
      r = (w == 1) ? ref_alu(int'(a1), int'(b1), int'(s1)) : ref_alu(int'(a0), int'(b0), int'(s0));
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      @(negedge clk);
      chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_y", 32'(rsp_y), 32'(r[15:0]));
      chk("rsp_dz", 32'(rsp_dz), 32'(r[16]));
      chk("rsp_id", 32'(rsp_id), 32'(w));
      oy = rsp_y; odz = rsp_dz; oid = rsp_id;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_y", 32'(rsp_y), 32'(r[15:0]));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
   endtask

   vec_t        tbl[7];
   logic [15:0] oy;
   logic        odz, oid;
   logic [16:0] r;

   initial begin
      tbl[0] = '{1'b0, 8'h21, 8'h11, 2'b00, 16'h0032, 1'b0};
      tbl[1] = '{1'b0, 8'h10, 8'h20, 2'b01, 16'hFFF0, 1'b0};
      tbl[2] = '{1'b0, 8'hFF, 8'hFF, 2'b10, 16'hFE01, 1'b0};
      tbl[3] = '{1'b0, 8'hFF, 8'hFF, 2'b00, 16'h01FE, 1'b0};
      tbl[4] = '{1'b0, 8'hE2, 8'hC1, 2'b11, 16'h0001, 1'b0};
      tbl[5] = '{1'b1, 8'h50, 8'h00, 2'b11, 16'hFFFF, 1'b1};
      tbl[6] = '{1'b1, 8'h07, 8'h03, 2'b11, 16'h0002, 1'b0};

      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_s = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_s = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("reset_req0_ready", 32'(req0_ready), 32'd0);
      chk("reset_req1_ready", 32'(req1_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_y", 32'(rsp_y), 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_rsp_dz", 32'(rsp_dz), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contention from reset: ids must come out 0, 1, 0.
      run_txn(1, 1, 8'h03, 8'h04, 2'b00, 8'h09, 8'h02, 2'b10, 0, oy, odz, oid);
      chk("contention_first", 32'(oid), 32'd0);
      run_txn(1, 1, 8'h03, 8'h04, 2'b00, 8'h09, 8'h02, 2'b10, 0, oy, odz, oid);
      chk("contention_second", 32'(oid), 32'd1);
      run_txn(1, 1, 8'h03, 8'h04, 2'b00, 8'h09, 8'h02, 2'b10, 0, oy, odz, oid);
      chk("contention_third", 32'(oid), 32'd0);

      foreach (tbl[i]) begin
         run_txn(!tbl[i].id, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].s,
                 tbl[i].a, tbl[i].b, tbl[i].s, 0, oy, odz, oid);
         chk("tbl_y", 32'(oy), 32'(tbl[i].y));
         chk("tbl_dz", 32'(odz), 32'(tbl[i].dz));
         chk("tbl_id", 32'(oid), 32'(tbl[i].id));
      end

      // A valid withdrawn before any clock edge must not count as a grant.
      req1_valid = 1'b1;
      #2;
      req1_valid = 1'b0;
      run_txn(1, 1, 8'h05, 8'h06, 2'b10, 8'h01, 8'h01, 2'b00, 0, oy, odz, oid);

      // Backpressure: req0 op held 5 cycles while req1 waits.
      req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h05; req0_s = 2'b01;
      #1;
      chk("bp_req0_ready", 32'(req0_ready), 32'd1);
      last_winner = 0;
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 8'h0A; req1_b = 8'h0B; req1_s = 2'b10;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_req1_ready_exec", 32'(req1_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_y", 32'(rsp_y), 32'h0007);
         chk("bp_id", 32'(rsp_id), 32'd0);
         chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_req1_accept", 32'(req1_ready), 32'd1);
      last_winner = 1;
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_req1_id", 32'(rsp_id), 32'd1);
      chk("bp_req1_y", 32'(rsp_y), 32'd110);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 60; n++) begin
         bit v0, v1;
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         run_txn(v0, v1, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                 2'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                 2'($urandom), int'($urandom_range(0, 3)), oy, odz, oid);
      end

      // Reset while a response is pending discards it and restores req0 priority.
      req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h11; req1_s = 2'b00;
      #1;
      chk("rst_mid_grant", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_resp", 32'(rsp_valid), 32'd1);
      r = ref_alu(8'h33, 8'h11, 0);
      chk("rst_mid_y", 32'(rsp_y), 32'(r[15:0]));
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rst_mid_req0_ready_low", 32'(req0_ready), 32'd0);
      @(negedge clk);
      chk("rst_mid_valid_cleared", 32'(rsp_valid), 32'd0);
      chk("rst_mid_y_cleared", 32'(rsp_y), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_req0_wins", 32'(req0_ready), 32'd1);
      chk("rst_mid_req1_waits", 32'(req1_ready), 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
